// File: rtl/imem_shift_buffer.sv
// Parametrised instruction-memory buffer: shift-in, addressed write and rotate,
// with a registered random-read port, a saturating fill counter and a freezable flat image.
module imem_shift_buffer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   in_valid,
    input  logic [1:0]             op,
    input  logic [WIDTH-1:0]       din,
    input  logic [AW-1:0]          wr_addr,
    input  logic [AW-1:0]          rd_addr,
    input  logic                   hold,
    output logic [WIDTH-1:0]       rd_data,
    output logic [WIDTH*DEPTH-1:0] data_out,
    output logic [CW-1:0]          count,
    output logic                   full
);

    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_SHIFT  = 2'b01,
        OP_WRITE  = 2'b10,
        OP_ROTATE = 2'b11
    } op_e;

    localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [WIDTH-1:0]       mem_d [DEPTH];
    logic [WIDTH-1:0]       rd_data_q, rd_data_d;
    logic [WIDTH*DEPTH-1:0] data_out_q, data_out_d;
    logic [WIDTH*DEPTH-1:0] mem_flat;
    logic [CW-1:0]          count_q, count_d;

    // Address matching by comparison keeps out-of-range addresses harmless for non-power-of-two depths.
    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
            count_d = '0;
        end else if (in_valid) begin
            case (op_e'(op))
                OP_SHIFT: begin
                    for (int i = 1; i < DEPTH; i++) mem_d[i] = mem_q[i-1];
                    mem_d[0] = din;
                    if (count_q != COUNT_MAX) count_d = count_q + CW'(1);
                end
                OP_WRITE: begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (wr_addr == AW'(i)) mem_d[i] = din;
                    end
                end
                OP_ROTATE: begin
                    for (int i = 1; i < DEPTH; i++) mem_d[i] = mem_q[i-1];
                    mem_d[0] = mem_q[DEPTH-1];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_data_d = '0;
        mem_flat  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_flat[i*WIDTH +: WIDTH] = mem_q[i];
            if (rd_addr == AW'(i)) rd_data_d = mem_q[i];
        end
        data_out_d = hold ? data_out_q : mem_flat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_data_q  <= '0;
            data_out_q <= '0;
            count_q    <= '0;
        end else begin
            mem_q      <= mem_d;
            rd_data_q  <= rd_data_d;
            data_out_q <= data_out_d;
            count_q    <= count_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign data_out = data_out_q;
    assign count    = count_q;
    assign full     = (count_q == COUNT_MAX);

endmodule

// File: tb/tb_imem_shift_buffer.sv
// Bench for imem_shift_buffer: a 4-deep and a 5-deep instance share stimulus and are
// checked every cycle against a queue-based model, plus hand-computed directed expectations.
module tb_imem_shift_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        inValid = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [7:0]  din = 8'h00;
    logic        hold = 1'b0;
    logic [1:0]  wrAddr4 = '0;
    logic [1:0]  rdAddr4 = '0;
    logic [2:0]  wrAddr5 = '0;
    logic [2:0]  rdAddr5 = '0;

    logic [7:0]  rdData4, rdData5;
    logic [31:0] dataOut4;
    logic [39:0] dataOut5;
    logic [2:0]  count4, count5;
    logic        full4, full5;

    int checks = 0;
    int failures = 0;
    bit cmpEn = 1'b0;

    localparam int DEP [2] = '{4, 5};
    logic [7:0] mMem [2][8];
    logic [7:0] mOut [2][8];
    logic [7:0] mRd [2];
    int         mCnt [2];

    imem_shift_buffer #(.WIDTH(8), .DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(inValid), .op(op), .din(din),
        .wr_addr(wrAddr4), .rd_addr(rdAddr4), .hold(hold),
        .rd_data(rdData4), .data_out(dataOut4), .count(count4), .full(full4)
    );

    imem_shift_buffer #(.WIDTH(8), .DEPTH(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(inValid), .op(op), .din(din),
        .wr_addr(wrAddr5), .rd_addr(rdAddr5), .hold(hold),
        .rd_data(rdData5), .data_out(dataOut5), .count(count5), .full(full5)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // The model treats memory as an ordered list: shift pushes at the front and drops the back,
    // rotate moves the back word to the front.
    function automatic void stepModel(int k, int wa, int ra);
        int d = DEP[k];
        logic [7:0] q [$];
        for (int i = 0; i < d; i++) q.push_back(mMem[k][i]);
        if (clear) begin
            foreach (q[i]) q[i] = 8'h00;
            mCnt[k] = 0;
        end else if (inValid) begin
            case (op)
                2'b01: begin
                    q.push_front(din);
                    void'(q.pop_back());
                    mCnt[k] = (mCnt[k] + 1 > d) ? d : mCnt[k] + 1;
                end
                2'b10: if (wa < d) q[wa] = din;
                2'b11: q.push_front(q.pop_back());
                default: ;
            endcase
        end
        mRd[k] = (ra < d) ? mMem[k][ra] : 8'h00;
        if (!hold) mOut[k] = mMem[k];
        for (int i = 0; i < d; i++) mMem[k][i] = q[i];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 8; i++) begin
                    mMem[k][i] = 8'h00;
                    mOut[k][i] = 8'h00;
                end
                mRd[k]  = 8'h00;
                mCnt[k] = 0;
            end
        end else begin
            stepModel(0, int'(wrAddr4), int'(rdAddr4));
            stepModel(1, int'(wrAddr5), int'(rdAddr5));
        end
    end

    always @(negedge clk) begin
        if (cmpEn) begin
            logic [31:0] exp4;
            logic [39:0] exp5;
            for (int i = 0; i < 4; i++) exp4[i*8 +: 8] = mOut[0][i];
            for (int i = 0; i < 5; i++) exp5[i*8 +: 8] = mOut[1][i];
            checkOutput("d4.data_out", 64'(dataOut4), 64'(exp4));
            checkOutput("d4.rd_data", 64'(rdData4), 64'(mRd[0]));
            checkOutput("d4.count", 64'(count4), 64'(mCnt[0]));
            checkOutput("d4.full", 64'(full4), 64'(mCnt[0] == 4));
            checkOutput("d5.data_out", 64'(dataOut5), 64'(exp5));
            checkOutput("d5.rd_data", 64'(rdData5), 64'(mRd[1]));
            checkOutput("d5.count", 64'(count5), 64'(mCnt[1]));
            checkOutput("d5.full", 64'(full5), 64'(mCnt[1] == 5));
        end
    end

    task automatic applyStimulus(input logic c, input logic v, input logic [1:0] o,
                                 input logic [7:0] d, input int wa4, input int wa5,
                                 input int ra4, input int ra5, input logic h);
        clear   = c;
        inValid = v;
        op      = o;
        din     = d;
        wrAddr4 = 2'(wa4);
        wrAddr5 = 3'(wa5);
        rdAddr4 = 2'(ra4);
        rdAddr5 = 3'(ra5);
        hold    = h;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] fillVals [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        int fillCounts [5] = '{1, 2, 3, 4, 4};
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cmpEn = 1'b1;

        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 2'b01, fillVals[i], 0, 0, 0, 0, 0);
            checkOutput("fill.count", 64'(count4), 64'(fillCounts[i]));
            checkOutput("fill.full", 64'(full4), 64'(i >= 3));
        end
        applyStimulus(0, 0, 2'b00, 8'h00, 0, 0, 0, 0, 0);
        checkOutput("fill.data_out", 64'(dataOut4), 64'h22334455);

        applyStimulus(0, 1, 2'b11, 8'h00, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 2'b00, 8'h00, 0, 0, 0, 0, 0);
        checkOutput("rotate.data_out", 64'(dataOut4), 64'h33445522);
        checkOutput("rotate.count", 64'(count4), 64'd4);

        applyStimulus(0, 1, 2'b10, 8'hAA, 2, 7, 2, 2, 0);
        checkOutput("write.rd_old", 64'(rdData4), 64'h44);
        applyStimulus(0, 0, 2'b00, 8'h00, 2, 7, 2, 2, 0);
        checkOutput("write.rd_new", 64'(rdData4), 64'hAA);
        checkOutput("write5.rd_dropped", 64'(rdData5), 64'h44);
        checkOutput("write5.data_out", 64'(dataOut5), 64'h2233445511);

        applyStimulus(0, 1, 2'b01, 8'h99, 0, 0, 0, 0, 1);
        checkOutput("hold.data_out1", 64'(dataOut4), 64'h33AA5522);
        applyStimulus(0, 0, 2'b00, 8'h00, 0, 0, 0, 0, 1);
        checkOutput("hold.data_out2", 64'(dataOut4), 64'h33AA5522);
        checkOutput("hold.rd_data", 64'(rdData4), 64'h99);
        applyStimulus(0, 0, 2'b00, 8'h00, 0, 0, 0, 0, 0);
        checkOutput("hold.release", 64'(dataOut4), 64'hAA552299);

        applyStimulus(1, 1, 2'b01, 8'h77, 0, 0, 0, 0, 0);
        checkOutput("clear.count", 64'(count4), 64'd0);
        checkOutput("clear.full", 64'(full4), 64'd0);
        checkOutput("clear.data_pre", 64'(dataOut4), 64'hAA552299);
        applyStimulus(0, 0, 2'b00, 8'h00, 0, 0, 0, 0, 0);
        checkOutput("clear.data_out", 64'(dataOut4), 64'h0);

        applyStimulus(0, 1, 2'b01, 8'h5A, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 2'b00, 8'h00, 0, 0, 0, 0, 0);
        checkOutput("prereset.count", 64'(count4), 64'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("areset.data_out", 64'(dataOut4), 64'h0);
        checkOutput("areset.rd_data", 64'(rdData4), 64'h0);
        checkOutput("areset.count", 64'(count4), 64'd0);
        checkOutput("areset.full", 64'(full4), 64'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);

        for (int n = 0; n < 400; n++) begin
            applyStimulus(logic'($urandom_range(0, 99) < 3), logic'($urandom_range(0, 99) < 80),
                          2'($urandom_range(0, 3)), 8'($urandom),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                          logic'($urandom_range(0, 99) < 25));
            if ($urandom_range(0, 99) == 0) begin
                @(posedge clk);
                #3 rst_n = 1'b0;
                #1 rst_n = 1'b1;
                @(negedge clk);
            end
        end

        cmpEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_shift_buffer.md
# imem_shift_buffer

Parametrised instruction-memory buffer that supersedes the fixed 64×16 shift memory. It holds DEPTH words of WIDTH bits and supports shift-in, addressed write, circular rotate and synchronous clear. It provides a registered random-read port, a fill counter with a full flag, and a flattened snapshot output that can be frozen. It sits between the instruction loader and the datapath that consumes the flattened image.

## Interface
- WIDTH, 16, bits per word (≥1)
- DEPTH, 64, number of words (≥2, need not be a power of two)
- AW, $clog2(DEPTH), localparam, address width
- CW, $clog2(DEPTH+1), localparam, count width
- clk  in  1  rising-edge clock, the only clock
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous clear of memory and count
- in_valid  in  1  qualifies op for this cycle
- op  in  2  00 nop, 01 shift-in, 10 addressed write, 11 rotate
- din  in  WIDTH  data for shift-in or write
- wr_addr  in  AW  target word for op 10
- rd_addr  in  AW  random-read address
- hold  in  1  freezes data_out when high
- rd_data  out  WIDTH  registered read data
- data_out  out  WIDTH*DEPTH  flattened image, word i at bits [i*WIDTH +: WIDTH]
- count  out  CW  words filled by shift-in, saturating at DEPTH
- full  out  1  count == DEPTH

## Operation
- Reset (rst_n low, async): all mem words, rd_data, data_out and count clear to 0; full clears to 0. Outputs hold these values while rst_n is low.
- Priority per cycle: clear, then op when in_valid=1, then hold state.
- clear=1: all mem words become 0 and count becomes 0. op is ignored. rd_data and data_out follow the normal rules below and are therefore sampled from pre-clear memory.
- op 01 shift-in: mem[i] ← mem[i-1] for i=DEPTH-1..1, and mem[0] ← din. mem[DEPTH-1] is discarded. count ← min(count+1, DEPTH).
- op 10 addressed write: mem[wr_addr] ← din if wr_addr < DEPTH. If wr_addr ≥ DEPTH the write is silently dropped. count is unchanged.
- op 11 rotate: mem[i] ← mem[i-1] and mem[0] ← mem[DEPTH-1]. No data is lost. count is unchanged.
- op 00, or in_valid=0: memory and count are unchanged.
- rd_data ← mem[rd_addr] every cycle, using pre-update memory (read-before-write). rd_data ← 0 if rd_addr ≥ DEPTH.
- data_out: every cycle with hold=0, data_out ← flattened pre-update memory. With hold=1, data_out keeps its value. Memory ops proceed underneath regardless of hold.
- full is combinational from count.

## Timing
- A memory update written at edge N is visible on rd_data and data_out after edge N+1. From op to output the latency is 2 edges; from memory state to output it is 1 edge.
- count and full reflect a shift-in after the same edge that performs it (latency 1).
- count saturates: a shift-in at count==DEPTH leaves count=DEPTH and full=1, and still shifts.
- clear and op asserted in the same cycle: clear wins. In the following cycle count=0 and full=0.
- hold released at edge M: data_out shows the memory as it was just before edge M, after edge M.
- rst_n asserted mid-operation: all state clears immediately. The first edge after rst_n deasserts executes normally.

## Test plan
- Reset: with WIDTH=8, DEPTH=4, pulse rst_n low mid-cycle while mem is non-zero -> data_out=0, rd_data=0, count=0 and full=0 immediately, without waiting for a clock edge.
- Fill: shift-in 0x11,0x22,0x33,0x44,0x55 on consecutive cycles -> count goes 1,2,3,4,4 and full=1 after the 4th shift. Two edges after the last shift, data_out={0x22,0x33,0x44,0x55} (word3..word0).
- Rotate: from that state issue one op 11 -> two edges later data_out={0x33,0x44,0x55,0x22} and count stays 4.
- Addressed write: op 10 with wr_addr=2, din=0xAA and rd_addr=2 in the same cycle -> rd_data returns the old value 0x44 one edge later and 0xAA on the next edge. A write with DEPTH=5 and wr_addr=7 changes nothing.
- Hold: set hold=1, then shift-in 0x99 -> data_out stays unchanged while rd_data at rd_addr=0 shows 0x99. Release hold -> data_out updates one edge later.
- Clear vs op: clear=1 together with in_valid=1, op=01 -> all words are 0, count=0 and full=0. data_out reads 0 two edges later.
